// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//
// Write-side master for the register file. Results from the load unit and
// the ALU are merged into one in-order FIFO, and the FIFO head drives the
// single synchronous register write port. At most one write per cycle.
// Writes to r0 are accepted but dropped. A pending-destination mask shows
// which registers still have queued writes.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ld_wb_valid/ready/dest/data    load unit writeback channel
//   alu_wb_valid/ready/dest/data   ALU writeback channel
//   reg_write_en/dest/data         register file write port
//   pending_mask                   bit i set = queued write to register i
//   queue_count                    occupied FIFO entries
//
// Handshake: a transfer happens on a rising edge where valid && ready on a
// port. The producer holds dest/data while valid is high and ready is low.
// Ready depends only on the occupancy at cycle start (plus ld_wb_valid for
// the ALU port), never on the same-cycle pop.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_wb_valid,
    output logic                       ld_wb_ready,
    input  logic [ADDR_W-1:0]          ld_wb_dest,
    input  logic [DATA_W-1:0]          ld_wb_data,
    input  logic                       alu_wb_valid,
    output logic                       alu_wb_ready,
    input  logic [ADDR_W-1:0]          alu_wb_dest,
    input  logic [DATA_W-1:0]          alu_wb_data,
    output logic                       reg_write_en,
    output logic [ADDR_W-1:0]          reg_write_dest,
    output logic [DATA_W-1:0]          reg_write_data,
    output logic [(2**ADDR_W)-1:0]     pending_mask,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NREG  = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [CNT_W-1:0]  free;
    logic              ld_rdy;
    logic              alu_rdy;
    logic              ld_enq;
    logic              alu_enq;
    logic              pop;
    logic [PTR_W-1:0]  alu_ptr;

    assign free = DEPTH_C - count;

    // Readies are forced low while reset is held. With one slot left the
    // load port wins it.
    assign ld_rdy  = rst_n && (free != '0);
    assign alu_rdy = rst_n && ((free >= CNT_W'(2)) ||
                               ((free == CNT_W'(1)) && !ld_wb_valid));

    // r0 transfers complete the handshake but take no slot.
    assign ld_enq  = ld_wb_valid  && ld_rdy  && (ld_wb_dest  != '0);
    assign alu_enq = alu_wb_valid && alu_rdy && (alu_wb_dest != '0);

    // Drain never stalls: the head retires on every edge with data queued.
    assign pop = (count != '0);

    // The ALU entry lands behind the load entry when both enqueue.
    assign alu_ptr = ld_enq ? (wr_ptr + PTR_W'(1)) : wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            valid_q <= '0;
        end else begin
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
            end
            if (ld_enq) begin
                valid_q[wr_ptr] <= 1'b1;
            end
            if (alu_enq) begin
                valid_q[alu_ptr] <= 1'b1;
            end
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(ld_enq) + PTR_W'(alu_enq);
            count  <= count + CNT_W'(ld_enq) + CNT_W'(alu_enq) - CNT_W'(pop);
        end
    end

    // Storage is intentionally not reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (ld_enq) begin
            dest_mem[wr_ptr] <= ld_wb_dest;
            data_mem[wr_ptr] <= ld_wb_data;
        end
        if (alu_enq) begin
            dest_mem[alu_ptr] <= alu_wb_dest;
            data_mem[alu_ptr] <= alu_wb_data;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pending_mask[dest_mem[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    assign ld_wb_ready    = ld_rdy;
    assign alu_wb_ready   = alu_rdy;
    assign reg_write_en   = pop;
    assign reg_write_dest = pop ? dest_mem[rd_ptr] : '0;
    assign reg_write_data = pop ? data_mem[rd_ptr] : '0;
    assign queue_count    = count;

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int EW     = ADDR_W + DATA_W;

    logic              clk;
    logic              rst_n;
    logic              ld_wb_valid;
    logic              ld_wb_ready;
    logic [ADDR_W-1:0] ld_wb_dest;
    logic [DATA_W-1:0] ld_wb_data;
    logic              alu_wb_valid;
    logic              alu_wb_ready;
    logic [ADDR_W-1:0] alu_wb_dest;
    logic [DATA_W-1:0] alu_wb_data;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic [7:0]        pending_mask;
    logic [2:0]        queue_count;

    // Reference model: exp_q holds {dest,data} of every entry the register
    // file still has to receive, in retire order. pend_q holds entries
    // accepted at the coming edge; they join exp_q after that edge.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] pend_q[$];

    int checks = 0;
    int errors = 0;

    reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld_wb_valid    (ld_wb_valid),
        .ld_wb_ready    (ld_wb_ready),
        .ld_wb_dest     (ld_wb_dest),
        .ld_wb_data     (ld_wb_data),
        .alu_wb_valid   (alu_wb_valid),
        .alu_wb_ready   (alu_wb_ready),
        .alu_wb_dest    (alu_wb_dest),
        .alu_wb_data    (alu_wb_data),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .pending_mask   (pending_mask),
        .queue_count    (queue_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One call = one cycle. Commits last cycle's accepted entries to the
    // model, applies new inputs, checks readies against the rules and
    // records what the coming edge will accept.
    task automatic drive(input bit lv, input logic [ADDR_W-1:0] ld, input logic [DATA_W-1:0] lda,
                         input bit av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] ada,
                         output bit l_acc, output bit a_acc);
        int  free;
        bit  exp_lr;
        bit  exp_ar;
        @(posedge clk);
        #1;
        while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        ld_wb_valid  = lv;
        ld_wb_dest   = ld;
        ld_wb_data   = lda;
        alu_wb_valid = av;
        alu_wb_dest  = ad;
        alu_wb_data  = ada;
        #1;
        free   = DEPTH - exp_q.size();
        exp_lr = rst_n && (free >= 1);
        exp_ar = rst_n && ((free >= 2) || (free == 1 && !lv));
        check("ld_wb_ready", 32'(ld_wb_ready), 32'(exp_lr));
        check("alu_wb_ready", 32'(alu_wb_ready), 32'(exp_ar));
        l_acc = lv && exp_lr;
        a_acc = av && exp_ar;
        if (l_acc && ld != 0) pend_q.push_back({ld, lda});
        if (a_acc && ad != 0) pend_q.push_back({ad, ada});
    endtask

    task automatic idle(input int n);
        bit la, aa;
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, la, aa);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [7:0] exp_mask;
        logic [EW-1:0] head;
        if (rst_n) begin
            exp_mask = '0;
            foreach (exp_q[i]) exp_mask[exp_q[i][EW-1:DATA_W]] = 1'b1;
            exp_mask[0] = 1'b0;
            check("queue_count", 32'(queue_count), 32'(exp_q.size()));
            check("count_le_depth", 32'(queue_count <= 3'(DEPTH)), 32'd1);
            check("pending_mask", 32'(pending_mask), 32'(exp_mask));
            check("reg_write_en", 32'(reg_write_en), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                head = exp_q.pop_front();
                check("reg_write_dest", 32'(reg_write_dest), 32'(head[EW-1:DATA_W]));
                check("reg_write_data", 32'(reg_write_data), 32'(head[DATA_W-1:0]));
            end else begin
                check("empty_dest", 32'(reg_write_dest), 32'd0);
                check("empty_data", 32'(reg_write_data), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit                lv, av, la, aa;
    logic [ADDR_W-1:0] ld, ad;
    logic [DATA_W-1:0] lda, ada;

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, 32'(reg_write_en), 32'd0);
        check({tag, "_dest"}, 32'(reg_write_dest), 32'd0);
        check({tag, "_data"}, 32'(reg_write_data), 32'd0);
        check({tag, "_count"}, 32'(queue_count), 32'd0);
        check({tag, "_mask"}, 32'(pending_mask), 32'd0);
        check({tag, "_ld_ready"}, 32'(ld_wb_ready), 32'd0);
        check({tag, "_alu_ready"}, 32'(alu_wb_ready), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        ld_wb_valid  = 1'b0;
        ld_wb_dest   = '0;
        ld_wb_data   = '0;
        alu_wb_valid = 1'b0;
        alu_wb_dest  = '0;
        alu_wb_data  = '0;
        #12;
        check_reset_outputs("por");
        rst_n = 1'b1;

        // single ALU write
        drive(0, '0, '0, 1, 3'd3, 16'h1234, la, aa);
        idle(3);
        // simultaneous load and ALU into empty queue
        drive(1, 3'd5, 16'hAAAA, 1, 3'd2, 16'h5555, la, aa);
        idle(4);
        // r0 discard
        drive(0, '0, '0, 1, 3'd0, 16'hFFFF, la, aa);
        check("r0_alu_accepted", 32'(aa), 32'd1);
        idle(3);
        // same destination ordering
        drive(1, 3'd4, 16'h0001, 0, '0, '0, la, aa);
        drive(0, '0, '0, 1, 3'd4, 16'h0002, la, aa);
        idle(4);

        // fill: both ports valid every cycle, holding on backpressure
        lv = 0; av = 0; la = 1; aa = 1;
        for (int c = 0; c < 12; c++) begin
            if (!lv || la) begin lv = 1; ld = 3'($urandom_range(1, 7)); lda = 16'($urandom); end
            if (!av || aa) begin av = 1; ad = 3'($urandom_range(1, 7)); ada = 16'($urandom); end
            drive(lv, ld, lda, av, ad, ada, la, aa);
        end
        idle(6);

        // randomized traffic
        lv = 0; av = 0; la = 1; aa = 1;
        for (int c = 0; c < 2000; c++) begin
            if (!lv || la) begin
                lv  = ($urandom_range(0, 3) != 0);
                ld  = 3'($urandom_range(0, 7));
                lda = 16'($urandom);
            end
            if (!av || aa) begin
                av  = ($urandom_range(0, 3) != 0);
                ad  = 3'($urandom_range(0, 7));
                ada = 16'($urandom);
            end
            drive(lv, ld, lda, av, ad, ada, la, aa);
        end
        idle(6);

        // reset mid-operation with three entries queued
        drive(1, 3'd1, 16'h1111, 1, 3'd6, 16'h6666, la, aa);
        drive(1, 3'd7, 16'h7777, 1, 3'd3, 16'h3333, la, aa);
        drive(0, '0, '0, 0, '0, '0, la, aa);
        check("pre_reset_count", 32'(queue_count), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        pend_q.delete();
        exp_q.delete();
        idle(2);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(4);
        drive(1, 3'd2, 16'hBEEF, 0, '0, '0, la, aa);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
